fetch_controller: RTL and testbench

- Sequences instruction fetch for the single-issue RV32 core.
- Drives the program counter's stall/jump/jumpSel controls and runs the instruction-memory req/gnt/rvalid handshake, with one request outstanding.
- Holds the returned word in a one-entry buffer for decode.
- Applies redirects from execute, flushes the buffer, and discards stale in-flight responses.

---
 rtl/fetch_controller.sv | 125 ++++++++++++
 tb/tb_fetch_controller.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: PC control, single-outstanding imem handshake, one-entry decode buffer.
// Optional misaligned-fetch fault reporting is enabled by defining FETCH_MISALIGN_EN.
module fetch_controller #(
    parameter int unsigned RESET_SKIP = 1,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic        redirect_i,
    input  logic [1:0]  redirect_sel_i,
    output logic        pc_stall_o,
    output logic        pc_jump_o,
    output logic [1:0]  pc_jump_sel_o,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic        flush_o,
    output logic        fault_o
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DISCARD} state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
        logic        fault;
    } ibuf_t;

    localparam logic [1:0] SKIP_LAST = 2'(RESET_SKIP - 1);

    state_t     state;
    logic [1:0] skip_cnt;
    ibuf_t      ibuf;
    logic       flush_q;

    logic misalign;
    logic req_act;
    logic granted;
    logic redir;
    logic accept;
    logic fault_load;

`ifdef FETCH_MISALIGN_EN
    assign misalign = (pc_i[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    // A redirect is ignored while the post-reset skip window is still running
    assign redir      = redirect_i && (state != S_IDLE);
    assign req_act    = (state == S_REQ) && !misalign;
    assign granted    = req_act && imem_gnt_i;
    assign accept     = (state == S_WAIT) && imem_rvalid_i && !redir;
    assign fault_load = (state == S_REQ) && misalign && !redir;

    assign imem_req_o    = req_act;
    assign imem_addr_o   = req_act ? pc_i : 32'h0;
    assign pc_jump_o     = redir;
    assign pc_jump_sel_o = redir ? redirect_sel_i : 2'b00;
    assign pc_stall_o    = !(accept || redir);

    assign instr_o       = ibuf.valid ? ibuf.instr : NOP_INSTR;
    assign instr_pc_o    = ibuf.pc;
    assign instr_valid_o = ibuf.valid;
    assign fault_o       = ibuf.fault;
    assign flush_o       = flush_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            skip_cnt <= 2'd0;
            ibuf     <= '{instr: NOP_INSTR, pc: 32'h0, valid: 1'b0, fault: 1'b0};
            flush_q  <= 1'b0;
        end else begin
            flush_q <= redir;

            // Refill wins over consume so a same-cycle hand-off keeps the new word
            if (redir) begin
                ibuf.instr <= NOP_INSTR;
                ibuf.valid <= 1'b0;
                ibuf.fault <= 1'b0;
            end else if (accept) begin
                ibuf <= '{instr: imem_rdata_i, pc: pc_i, valid: 1'b1, fault: 1'b0};
            end else if (fault_load) begin
                ibuf <= '{instr: NOP_INSTR, pc: pc_i, valid: 1'b1, fault: 1'b1};
            end else if (instr_ready_i) begin
                ibuf.valid <= 1'b0;
                ibuf.fault <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (skip_cnt == SKIP_LAST) state <= S_REQ;
                    else                       skip_cnt <= skip_cnt + 2'd1;
                end
                S_REQ: begin
                    if (redir)         state <= granted ? S_DISCARD : S_REQ;
                    else if (misalign) state <= S_HOLD;
                    else if (granted)  state <= S_WAIT;
                end
                S_WAIT: begin
                    // A response racing the redirect is simply dropped; nothing left in flight
                    if (redir)              state <= imem_rvalid_i ? S_REQ : S_DISCARD;
                    else if (imem_rvalid_i) state <= instr_ready_i ? S_REQ : S_HOLD;
                end
                S_HOLD: begin
                    if (redir || instr_ready_i) state <= S_REQ;
                end
                S_DISCARD: begin
                    if (imem_rvalid_i) state <= S_REQ;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed vector bench for fetch_controller: cycle table plus hand sequences for throughput and misalign.
module tb_fetch_controller;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc_i = '0;
    logic        redirect_i = 1'b0;
    logic [1:0]  redirect_sel_i = '0;
    logic        pc_stall_o, pc_jump_o;
    logic [1:0]  pc_jump_sel_o;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic [31:0] instr_o, instr_pc_o;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b0;
    logic        flush_o, fault_o;

    int checks = 0;
    int errors = 0;

    fetch_controller #(.RESET_SKIP(1), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst), .pc_i(pc_i),
        .redirect_i(redirect_i), .redirect_sel_i(redirect_sel_i),
        .pc_stall_o(pc_stall_o), .pc_jump_o(pc_jump_o), .pc_jump_sel_o(pc_jump_sel_o),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .instr_o(instr_o), .instr_pc_o(instr_pc_o), .instr_valid_o(instr_valid_o),
        .instr_ready_i(instr_ready_i), .flush_o(flush_o), .fault_o(fault_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic [31:0] pc;
        logic        redir;
        logic [1:0]  sel;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        rdy;
    } in_t;

    typedef struct packed {
        logic        stall;
        logic        jump;
        logic [1:0]  jsel;
        logic        req;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] ipc;
        logic        valid;
        logic        flush;
        logic        fault;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs [NV];

    function automatic in_t mi(logic r, logic [31:0] pc, logic rd, logic [1:0] sel,
                               logic gnt, logic rv, logic [31:0] rdata, logic rdy);
        mi = '{rst: r, pc: pc, redir: rd, sel: sel, gnt: gnt, rv: rv, rdata: rdata, rdy: rdy};
    endfunction

    function automatic out_t mo(logic st, logic jp, logic [1:0] js, logic rq, logic [31:0] ad,
                                logic [31:0] ins, logic [31:0] ipc, logic v, logic fl, logic ft);
        mo = '{stall: st, jump: jp, jsel: js, req: rq, addr: ad, instr: ins, ipc: ipc,
               valid: v, flush: fl, fault: ft};
    endfunction

    function automatic out_t sample();
        sample = '{stall: pc_stall_o, jump: pc_jump_o, jsel: pc_jump_sel_o, req: imem_req_o,
                   addr: imem_addr_o, instr: instr_o, ipc: instr_pc_o, valid: instr_valid_o,
                   flush: flush_o, fault: fault_o};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input in_t v);
        rst            = v.rst;
        pc_i           = v.pc;
        redirect_i     = v.redir;
        redirect_sel_i = v.sel;
        imem_gnt_i     = v.gnt;
        imem_rvalid_i  = v.rv;
        imem_rdata_i   = v.rdata;
        instr_ready_i  = v.rdy;
    endtask

    initial begin
        out_t        rs;
        int          acc;
        logic        gnt_prev;
        logic [31:0] pc_m, last_pc, last_data;
        logic        have_last;

        rs = mo(1, 0, 0, 0, 0, NOP, 0, 0, 0, 0);
        // reset, first fill, second fill into HOLD, consume
        vecs[0]  = '{mi(0, 32'h00, 0, 0, 0, 0, 32'h0, 0),        rs};
        vecs[1]  = '{mi(1, 32'h00, 0, 0, 1, 0, 32'h0, 1),        rs};
        vecs[2]  = '{mi(1, 32'h00, 0, 0, 1, 0, 32'h0, 1),        mo(1, 0, 0, 1, 32'h00, NOP, 0, 0, 0, 0)};
        vecs[3]  = '{mi(1, 32'h00, 0, 0, 1, 1, 32'h00500093, 1), mo(0, 0, 0, 0, 32'h00, NOP, 0, 0, 0, 0)};
        vecs[4]  = '{mi(1, 32'h04, 0, 0, 1, 0, 32'h0, 1),        mo(1, 0, 0, 1, 32'h04, 32'h00500093, 0, 1, 0, 0)};
        vecs[5]  = '{mi(1, 32'h04, 0, 0, 1, 1, 32'h00100113, 0), mo(0, 0, 0, 0, 32'h00, NOP, 0, 0, 0, 0)};
        vecs[6]  = '{mi(1, 32'h08, 0, 0, 1, 0, 32'h0, 0),        mo(1, 0, 0, 0, 32'h00, 32'h00100113, 4, 1, 0, 0)};
        vecs[7]  = '{mi(1, 32'h08, 0, 0, 1, 0, 32'h0, 0),        mo(1, 0, 0, 0, 32'h00, 32'h00100113, 4, 1, 0, 0)};
        vecs[8]  = '{mi(1, 32'h08, 0, 0, 1, 0, 32'h0, 1),        mo(1, 0, 0, 0, 32'h00, 32'h00100113, 4, 1, 0, 0)};
        // ungranted request holds, then redirect in WAIT and late response discarded
        vecs[9]  = '{mi(1, 32'h08, 0, 0, 0, 0, 32'h0, 0),        mo(1, 0, 0, 1, 32'h08, NOP, 4, 0, 0, 0)};
        vecs[10] = '{mi(1, 32'h08, 0, 0, 1, 0, 32'h0, 0),        mo(1, 0, 0, 1, 32'h08, NOP, 4, 0, 0, 0)};
        vecs[11] = '{mi(1, 32'h08, 1, 1, 1, 0, 32'h0, 0),        mo(0, 1, 1, 0, 32'h00, NOP, 4, 0, 0, 0)};
        vecs[12] = '{mi(1, 32'h40, 0, 0, 0, 0, 32'h0, 0),        mo(1, 0, 0, 0, 32'h00, NOP, 4, 0, 1, 0)};
        vecs[13] = '{mi(1, 32'h40, 0, 0, 0, 0, 32'h0, 0),        mo(1, 0, 0, 0, 32'h00, NOP, 4, 0, 0, 0)};
        vecs[14] = '{mi(1, 32'h40, 0, 0, 0, 1, 32'hDEADBEEF, 1), mo(1, 0, 0, 0, 32'h00, NOP, 4, 0, 0, 0)};
        vecs[15] = '{mi(1, 32'h40, 0, 0, 1, 0, 32'h0, 1),        mo(1, 0, 0, 1, 32'h40, NOP, 4, 0, 0, 0)};
        // redirect coincident with rvalid, then redirect from REQ without grant, sel=3
        vecs[16] = '{mi(1, 32'h40, 1, 2, 0, 1, 32'h11111111, 1), mo(0, 1, 2, 0, 32'h00, NOP, 4, 0, 0, 0)};
        vecs[17] = '{mi(1, 32'h80, 0, 0, 0, 0, 32'h0, 0),        mo(1, 0, 0, 1, 32'h80, NOP, 4, 0, 1, 0)};
        vecs[18] = '{mi(1, 32'h80, 1, 3, 0, 0, 32'h0, 0),        mo(0, 1, 3, 1, 32'h80, NOP, 4, 0, 0, 0)};
        vecs[19] = '{mi(1, 32'h84, 0, 0, 1, 0, 32'h0, 0),        mo(1, 0, 0, 1, 32'h84, NOP, 4, 0, 1, 0)};
        // reset during WAIT, stray rvalid and redirect in IDLE ignored
        vecs[20] = '{mi(0, 32'h84, 0, 0, 0, 0, 32'h0, 0),        rs};
        vecs[21] = '{mi(0, 32'h00, 0, 0, 0, 1, 32'hCAFEF00D, 0), rs};
        vecs[22] = '{mi(1, 32'h00, 1, 1, 0, 1, 32'hCAFEF00D, 1), rs};
        vecs[23] = '{mi(1, 32'h00, 0, 0, 0, 0, 32'h0, 0),        mo(1, 0, 0, 1, 32'h00, NOP, 0, 0, 0, 0)};

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].i);
            #1;
            chk($sformatf("vec%0d", i), 128'(sample()), 128'(vecs[i].o));
        end

        // Streaming with gnt held and rvalid one cycle after grant: one word per two cycles
        acc = 0; gnt_prev = 1'b0; pc_m = 32'h0; have_last = 1'b0;
        last_pc = '0; last_data = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            pc_i          = pc_m;
            imem_gnt_i    = 1'b1;
            imem_rvalid_i = gnt_prev;
            imem_rdata_i  = 32'h1000_0000 | pc_m;
            instr_ready_i = 1'b1;
            redirect_i    = 1'b0;
            #1;
            if (have_last) begin
                chk("stream_instr", 128'(instr_o), 128'(last_data));
                chk("stream_pc", 128'(instr_pc_o), 128'(last_pc));
            end
            have_last = 1'b0;
            chk("stream_stall", 128'(pc_stall_o), 128'(!gnt_prev));
            if (!pc_stall_o) begin
                acc++;
                have_last = 1'b1;
                last_pc   = pc_m;
                last_data = 32'h1000_0000 | pc_m;
                pc_m      = pc_m + 32'd4;
            end
            gnt_prev = imem_req_o && imem_gnt_i;
        end
        chk("stream_rate", 128'(acc), 128'(10));

`ifdef FETCH_MISALIGN_EN
        @(negedge clk);
        drive(mi(0, 32'h102, 0, 0, 1, 0, 32'h0, 0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("mis_req", 128'({imem_req_o, pc_stall_o}), 128'(2'b01));
        @(negedge clk);
        #1;
        chk("mis_buf", 128'({fault_o, instr_valid_o, instr_pc_o, instr_o, imem_req_o, pc_stall_o}),
            128'({1'b1, 1'b1, 32'h102, NOP, 1'b0, 1'b1}));
        redirect_i = 1'b1; redirect_sel_i = 2'd2;
        #1;
        chk("mis_jump", 128'({pc_jump_o, pc_jump_sel_o, pc_stall_o}), 128'({1'b1, 2'd2, 1'b0}));
        @(negedge clk);
        redirect_i = 1'b0; pc_i = 32'h200;
        #1;
        chk("mis_resume", 128'({fault_o, instr_valid_o, flush_o, imem_req_o, imem_addr_o}),
            128'({1'b0, 1'b0, 1'b1, 1'b1, 32'h200}));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
